arena_boundary: RTL and testbench

ARENA_BOUNDARY -- requirements
Module: arena_boundary

---
 rtl/arena_pkg.sv | 15 +
 rtl/in_wall.sv | 32 +++
 rtl/arena_boundary.sv | 148 ++++++++++++++
 tb/tb_arena_boundary.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arena_pkg.sv
// Shared screen geometry and arena FSM state encoding for the arena boundary block.
// Pure definitions: no logic, no latency, no flow control.
package arena_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } arena_state_t;

endpackage

// File: rtl/in_wall.sv
// Combinational wall-membership test for one coordinate against the current wall thickness.
// Zero latency; no flow control (pure function of its inputs).
module in_wall
  import arena_pkg::*;
#(
  parameter int H_ACTIVE = SCREEN_W,
  parameter int V_ACTIVE = SCREEN_H
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] margin,
  output logic               hit
);

  logic [COORD_W:0] x_ext;
  logic [COORD_W:0] y_ext;
  logic [COORD_W:0] x_far;
  logic [COORD_W:0] y_far;

  // x >= H - margin is rewritten as x + margin >= H to stay in unsigned arithmetic
  always_comb begin
    x_ext = {1'b0, x};
    y_ext = {1'b0, y};
    x_far = x_ext + {1'b0, margin};
    y_far = y_ext + {1'b0, margin};
    hit   = (x_ext < (COORD_W+1)'(H_ACTIVE)) &&
            (y_ext < (COORD_W+1)'(V_ACTIVE)) &&
            ((x < margin) || (x_far >= (COORD_W+1)'(H_ACTIVE)) ||
             (y < margin) || (y_far >= (COORD_W+1)'(V_ACTIVE)));
  end

endmodule

// File: rtl/arena_boundary.sv
// Arena wall renderer with shrinking margin, head collision detection and post-hit blinking.
// boundary is 1 cycle after pixel_x/pixel_y; wall_hit 1 cycle after head_valid; no backpressure.
module arena_boundary
  import arena_pkg::*;
#(
  parameter int H_ACTIVE      = SCREEN_W,
  parameter int V_ACTIVE      = SCREEN_H,
  parameter int WALL_INIT     = 30,
  parameter int WALL_MAX      = 150,
  parameter int SHRINK_STEP   = 10,
  parameter int SHRINK_FRAMES = 60,
  parameter int BLINK_FRAMES  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               frame_tick,
  input  logic               game_run,
  input  logic               shrink_en,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               head_valid,
  output logic               boundary,
  output logic               wall_hit,
  output logic [COORD_W-1:0] margin,
  output logic               shrink_pulse
);

  localparam int FCW = $clog2(SHRINK_FRAMES + 1);
  localparam int BCW = $clog2(BLINK_FRAMES + 1);
  localparam logic [COORD_W-1:0] MARGIN_INIT = COORD_W'(WALL_INIT);
  localparam logic [COORD_W-1:0] MARGIN_MAX  = COORD_W'(WALL_MAX);

  arena_state_t     state_q, state_d;
  logic [COORD_W-1:0] margin_q, margin_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BCW-1:0]   blink_cnt_q, blink_cnt_d;
  logic             vis_q, vis_d;
  logic             wall_hit_q, wall_hit_d;
  logic             shrink_pulse_q, shrink_pulse_d;
  logic             boundary_q, boundary_d;
  logic             go_idle;
  logic             pix_wall;
  logic             head_wall;
  logic [COORD_W:0] grown;

  // Both paths test against margin_q, so a head strobe coinciding with a shrink sees the old wall
  in_wall #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_pix_wall (
    .x(pixel_x), .y(pixel_y), .margin(margin_q), .hit(pix_wall)
  );

  in_wall #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_head_wall (
    .x(head_x), .y(head_y), .margin(margin_q), .hit(head_wall)
  );

  assign grown = {1'b0, margin_q} + (COORD_W+1)'(SHRINK_STEP);

  always_comb begin
    state_d        = state_q;
    margin_d       = margin_q;
    frame_cnt_d    = frame_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    vis_d          = vis_q;
    wall_hit_d     = wall_hit_q;
    shrink_pulse_d = 1'b0;
    boundary_d     = pix_wall & vis_q;
    go_idle        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (game_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!game_run) begin
          go_idle = 1'b1;
        end else begin
          if (head_valid && head_wall) begin
            state_d    = ST_HIT;
            wall_hit_d = 1'b1;
          end
          if (shrink_en && frame_tick) begin
            if (frame_cnt_q == FCW'(SHRINK_FRAMES - 1)) begin
              frame_cnt_d = '0;
              if (margin_q < MARGIN_MAX) begin
                margin_d       = (grown >= {1'b0, MARGIN_MAX}) ? MARGIN_MAX : grown[COORD_W-1:0];
                shrink_pulse_d = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + FCW'(1);
            end
          end
        end
      end
      ST_HIT: begin
        if (!game_run) begin
          go_idle = 1'b1;
        end else if (frame_tick) begin
          if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
            blink_cnt_d = '0;
            vis_d       = ~vis_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BCW'(1);
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Entering IDLE discards all shrink and blink progress
    if (go_idle) begin
      state_d     = ST_IDLE;
      margin_d    = MARGIN_INIT;
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      vis_d       = 1'b1;
      wall_hit_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      margin_q       <= MARGIN_INIT;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      vis_q          <= 1'b1;
      wall_hit_q     <= 1'b0;
      shrink_pulse_q <= 1'b0;
      boundary_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      margin_q       <= margin_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      vis_q          <= vis_d;
      wall_hit_q     <= wall_hit_d;
      shrink_pulse_q <= shrink_pulse_d;
      boundary_q     <= boundary_d;
    end
  end

  assign boundary     = boundary_q;
  assign wall_hit     = wall_hit_q;
  assign margin       = margin_q;
  assign shrink_pulse = shrink_pulse_q;

endmodule

// File: tb/tb_arena_boundary.sv
// Self-checking bench for arena_boundary: directed scenarios plus randomized traffic
// compared every cycle against a frame-count based reference model.
module tb_arena_boundary;

  localparam int WALL_INIT     = 30;
  localparam int WALL_MAX      = 150;
  localparam int SHRINK_STEP   = 10;
  localparam int SHRINK_FRAMES = 60;
  localparam int BLINK_FRAMES  = 15;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HIT  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       frame_tick = 1'b0;
  logic       game_run = 1'b0;
  logic       shrink_en = 1'b0;
  logic [9:0] head_x = '0;
  logic [9:0] head_y = '0;
  logic       head_valid = 1'b0;
  logic       boundary;
  logic       wall_hit;
  logic [9:0] margin;
  logic       shrink_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_seen = 0;
  bit rand_pix = 1'b0;

  // Reference model: margin derived from the number of shrink-enabled frames seen in RUN
  int m_st;
  int m_shr;
  int m_hit_ticks;
  bit m_hit;
  bit m_bnd;
  bit m_pulse;

  arena_boundary dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .game_run(game_run), .shrink_en(shrink_en),
    .head_x(head_x), .head_y(head_y), .head_valid(head_valid),
    .boundary(boundary), .wall_hit(wall_hit), .margin(margin), .shrink_pulse(shrink_pulse)
  );

  always #5 clk = ~clk;

  function automatic bit in_wall_m(int x, int y, int m);
    return (x < 640) && (y < 480) && (x < m || x >= 640 - m || y < m || y >= 480 - m);
  endfunction

  function automatic int m_margin();
    int v;
    v = WALL_INIT + SHRINK_STEP * (m_shr / SHRINK_FRAMES);
    return (v > WALL_MAX) ? WALL_MAX : v;
  endfunction

  function automatic bit m_vis();
    return (m_st != M_HIT) || (((m_hit_ticks / BLINK_FRAMES) % 2) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_shr = 0; m_hit_ticks = 0;
    m_hit = 1'b0; m_bnd = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_to_idle();
    m_st = M_IDLE; m_shr = 0; m_hit_ticks = 0; m_hit = 1'b0;
  endtask

  task automatic model_edge();
    int old_m;
    bit vis;
    if (reset) begin
      model_reset();
      return;
    end
    old_m   = m_margin();
    vis     = m_vis();
    m_bnd   = in_wall_m(int'(pixel_x), int'(pixel_y), old_m) && vis;
    m_pulse = 1'b0;
    case (m_st)
      M_IDLE: if (game_run) m_st = M_RUN;
      M_RUN: begin
        if (!game_run) begin
          model_to_idle();
        end else begin
          if (head_valid && in_wall_m(int'(head_x), int'(head_y), old_m)) begin
            m_st = M_HIT; m_hit = 1'b1; m_hit_ticks = 0;
          end
          if (shrink_en && frame_tick) begin
            m_shr++;
            m_pulse = (m_margin() > old_m);
          end
        end
      end
      default: begin
        if (!game_run) model_to_idle();
        else if (frame_tick) m_hit_ticks++;
      end
    endcase
  endtask

  task automatic step();
    if (rand_pix) begin
      pixel_x = ($urandom % 2 == 0) ? 10'($urandom_range(0, 200)) : 10'($urandom_range(450, 700));
      pixel_y = ($urandom % 2 == 0) ? 10'($urandom_range(0, 180)) : 10'($urandom_range(300, 520));
    end
    model_edge();
    @(posedge clk);
    #1;
    if (shrink_pulse === 1'b1) pulse_seen++;
    chk("boundary", boundary, m_bnd);
    chk("wall_hit", wall_hit, m_hit);
    chk("margin", margin, m_margin());
    chk("shrink_pulse", shrink_pulse, m_pulse);
  endtask

  task automatic frames(input int n, input bit rand_head);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      if (rand_head) begin
        head_valid = 1'($urandom % 2);
        head_x = 10'($urandom_range(0, 639));
        head_y = 10'($urandom_range(0, 479));
      end
      step();
      frame_tick = 1'b0;
      head_valid = 1'b0;
      step();
    end
  endtask

  task automatic head_strobe(input int x, input int y);
    head_x = 10'(x); head_y = 10'(y); head_valid = 1'b1;
    step();
    head_valid = 1'b0;
  endtask

  int px_t [4] = '{29, 30, 610, 640};
  int py_t [4] = '{100, 100, 240, 0};
  int bd_t [4] = '{1, 0, 1, 0};

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_boundary", boundary, 0);
    chk("rst_wall_hit", wall_hit, 0);
    chk("rst_margin", margin, WALL_INIT);
    chk("rst_pulse", shrink_pulse, 0);
    step();
    step();
    reset = 1'b0;

    // Idle scan pixels
    for (int i = 0; i < 4; i++) begin
      pixel_x = 10'(px_t[i]); pixel_y = 10'(py_t[i]);
      step();
      chk("idle_pixel", boundary, bd_t[i]);
    end

    // Run: hit test uses the pre-shrink margin on the shrink frame
    game_run = 1'b1; shrink_en = 1'b1; rand_pix = 1'b1;
    step();
    frames(30, 1'b0);
    head_strobe(320, 240);
    chk("no_hit_center", wall_hit, 0);
    frames(29, 1'b0);
    frame_tick = 1'b1;
    head_strobe(35, 200);
    frame_tick = 1'b0;
    chk("shrink_margin", margin, 40);
    chk("shrink_pulse_hi", shrink_pulse, 1);
    chk("no_hit_old_margin", wall_hit, 0);
    step();
    chk("shrink_pulse_lo", shrink_pulse, 0);
    rand_pix = 1'b0; pixel_x = 10'd35; pixel_y = 10'd200;
    step();
    chk("pixel_35_200", boundary, 1);
    frames(1, 1'b0);
    head_strobe(35, 200);
    chk("hit_new_margin", wall_hit, 1);
    pixel_x = 10'd0; pixel_y = 10'd0;
    game_run = 1'b0;
    step();
    chk("idle_clr_hit", wall_hit, 0);
    chk("idle_margin", margin, WALL_INIT);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_steady", boundary, 1);
    end

    // Freeze with shrink_en=0, then hit and blink
    game_run = 1'b1; shrink_en = 1'b0; rand_pix = 1'b1;
    step();
    frames(70, 1'b0);
    chk("frozen_margin", margin, WALL_INIT);
    shrink_en = 1'b1; frames(20, 1'b0);
    shrink_en = 1'b0; frames(50, 1'b0);
    shrink_en = 1'b1; frames(40, 1'b0);
    chk("resume_margin", margin, 40);
    head_strobe(320, 240);
    chk("no_hit_center2", wall_hit, 0);
    head_strobe(5, 240);
    chk("hit_5_240", wall_hit, 1);
    rand_pix = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
    frames(14, 1'b1);
    chk("blink_on", boundary, 1);
    frames(1, 1'b1);
    chk("blink_off", boundary, 0);
    frames(14, 1'b1);
    chk("blink_still_off", boundary, 0);
    frames(1, 1'b1);
    chk("blink_on_again", boundary, 1);
    chk("hit_margin_frozen", margin, 40);
    chk("hit_sticky", wall_hit, 1);
    game_run = 1'b0;
    step();
    chk("idle_clr_hit2", wall_hit, 0);

    // Asynchronous reset mid-frame at margin 90, then saturation
    game_run = 1'b1; shrink_en = 1'b1;
    step();
    frames(360, 1'b0);
    chk("margin_90", margin, 90);
    chk("bnd_before_rst", boundary, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_margin", margin, WALL_INIT);
    chk("async_rst_boundary", boundary, 0);
    step();
    reset = 1'b0;
    step();
    pulse_seen = 0;
    frames(60, 1'b0);
    chk("after_rst_margin", margin, 40);
    frames(720, 1'b0);
    chk("sat_margin", margin, WALL_MAX);
    chk("sat_pulses", pulse_seen, 12);

    // Randomized traffic
    game_run = 1'b0;
    step();
    rand_pix = 1'b1; game_run = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) game_run = ~game_run;
      if ($urandom_range(0, 99) < 3) shrink_en = ~shrink_en;
      frame_tick = ($urandom % 3 == 0);
      head_valid = ($urandom % 25 == 0);
      head_x = 10'($urandom_range(0, 700));
      head_y = 10'($urandom_range(0, 520));
      step();
    end
    frame_tick = 1'b0; head_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
